// File: rtl/bennett_alu_datapath.sv
// 16-bit ALU datapath with an integrated WIDTH-phase Bennett clock sequencer.
// Phase rails ramp up one per step, peak at step WIDTH, then ramp down in reverse.
module bennett_alu_datapath #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  output logic             instFlag,
  output logic [WIDTH-1:0] clkp,
  output logic [WIDTH-1:0] clkn,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [15:0]      PC_in,
  input  logic [15:0]      instr_in,
  input  logic             A_mux,
  input  logic             B_mux1,
  input  logic             B_mux0,
  input  logic             ALU_Control1,
  input  logic             ALU_Control0,
  input  logic             SUB,
  input  logic             STL,
  input  logic             Adder_Cin,
  input  logic             mux3_1,
  input  logic             mux3_0,
  input  logic             ALU_O_Fclkpos,
  input  logic             A_Fclkpos,
  output logic [15:0]      alu_out,
  output logic [15:0]      out,
  output logic [15:0]      SRAM_in,
  output logic             out_Zero_Detect,
  output logic             ALU_OUT_Fclkneg,
  output logic             A_Fclkneg_out
);

  localparam int PERIOD = 2 * WIDTH;
  localparam int SW     = $clog2(PERIOD);

  logic [SW-1:0]    step;
  logic [WIDTH-1:0] rails_next;

  // Rail i is high while the ramp has passed it going up, or not yet reached it going down.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
    rails_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(step) <= WIDTH) rails_next[i] = (i < int'(step));
      else                     rails_next[i] = (i < PERIOD - int'(step));
    end
  end

  // Outputs are registered from the current step, so they show step s one cycle after the counter holds s.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      step     <= '0;
      clkp     <= '0;
      instFlag <= 1'b0;
    end else begin
      if (step == SW'(PERIOD - 1)) step <= '0;
      else                         step <= step + 1'b1;
      clkp     <= rails_next;
      instFlag <= (step == '0);
    end
  end

  assign clkn = ~clkp;

  // Operand selection
  logic [15:0] op_a, op_b;
  logic [1:0]  b_sel, alu_sel, out_sel;

  assign b_sel   = {B_mux1, B_mux0};
  assign alu_sel = {ALU_Control1, ALU_Control0};
  assign out_sel = {mux3_1, mux3_0};
  assign op_a    = A_mux ? a : PC_in;

  always_comb begin
    op_b = 16'h0001;
    case (b_sel)
      2'b00: op_b = 16'h0001;
      2'b01: op_b = {{8{instr_in[7]}}, instr_in[7:0]};
      2'b10: op_b = {8'h00, instr_in[7:0]};
      2'b11: op_b = b;
      default: op_b = 16'h0001;
    endcase
  end

  // Main adder honours SUB/Cin; the compare path is always a true subtraction.
  logic [15:0] sum, diff, adder_path, result;
  logic        slt;

  assign sum  = op_a + (SUB ? ~op_b : op_b) + {15'b0, SUB | Adder_Cin};
  assign diff = op_a + ~op_b + 16'h0001;
  assign slt  = diff[15] ^ ((op_a[15] != op_b[15]) && (diff[15] != op_a[15]));
  assign adder_path = STL ? {15'b0, slt} : sum;

  always_comb begin
    result = '0;
    case (alu_sel)
      2'b00: result = op_a & op_b;
      2'b01: result = op_a | op_b;
      2'b10: result = adder_path;
      2'b11: result = op_a ^ op_b;
      default: result = '0;
    endcase
  end

  assign out_Zero_Detect = (result == 16'h0000);

  always_comb begin
    out = result;
    case (out_sel)
      2'b00: out = result;
      2'b01: out = PC_in;
      2'b10: out = instr_in;
      2'b11: out = alu_out;
      default: out = result;
    endcase
  end

  // Capture registers; reset wins over both strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out         <= '0;
      SRAM_in         <= '0;
      ALU_OUT_Fclkneg <= 1'b1;
      A_Fclkneg_out   <= 1'b1;
    end else begin
      if (ALU_O_Fclkpos) alu_out <= result;
      if (A_Fclkpos)     SRAM_in <= op_a;
      ALU_OUT_Fclkneg <= ~ALU_O_Fclkpos;
      A_Fclkneg_out   <= ~A_Fclkpos;
    end
  end

endmodule

// File: tb/tb_bennett_alu_datapath.sv
// Directed bench for bennett_alu_datapath: sequencer waveform, ALU ops, capture strobes, reset.
module tb_bennett_alu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        instFlag;
  logic [12:0] clkp, clkn;
  logic [15:0] a, b, PC_in, instr_in;
  logic        A_mux, B_mux1, B_mux0, ALU_Control1, ALU_Control0;
  logic        SUB, STL, Adder_Cin, mux3_1, mux3_0;
  logic        ALU_O_Fclkpos, A_Fclkpos;
  logic [15:0] alu_out, out, SRAM_in;
  logic        out_Zero_Detect, ALU_OUT_Fclkneg, A_Fclkneg_out;

  int n_tests = 0;
  int n_fail  = 0;

  bennett_alu_datapath #(.WIDTH(13)) dut (
    .clk(clk), .reset(reset), .instFlag(instFlag), .clkp(clkp), .clkn(clkn),
    .a(a), .b(b), .PC_in(PC_in), .instr_in(instr_in),
    .A_mux(A_mux), .B_mux1(B_mux1), .B_mux0(B_mux0),
    .ALU_Control1(ALU_Control1), .ALU_Control0(ALU_Control0),
    .SUB(SUB), .STL(STL), .Adder_Cin(Adder_Cin),
    .mux3_1(mux3_1), .mux3_0(mux3_0),
    .ALU_O_Fclkpos(ALU_O_Fclkpos), .A_Fclkpos(A_Fclkpos),
    .alu_out(alu_out), .out(out), .SRAM_in(SRAM_in),
    .out_Zero_Detect(out_Zero_Detect),
    .ALU_OUT_Fclkneg(ALU_OUT_Fclkneg), .A_Fclkneg_out(A_Fclkneg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  logic [31:0] exp_rails;

  initial begin
    reset = 1'b1;
    a = '0; b = '0; PC_in = '0; instr_in = '0;
    A_mux = 0; B_mux1 = 0; B_mux0 = 0; ALU_Control1 = 0; ALU_Control0 = 0;
    SUB = 0; STL = 0; Adder_Cin = 0; mux3_1 = 0; mux3_0 = 0;
    ALU_O_Fclkpos = 0; A_Fclkpos = 0;

    repeat (3) tick();
    check("rst_instflag", 32'(instFlag), 32'd0);
    check("rst_clkp",     32'(clkp),     32'h0000);
    check("rst_clkn",     32'(clkn),     32'h1FFF);
    check("rst_alu_out",  32'(alu_out),  32'h0000);
    check("rst_sram_in",  32'(SRAM_in),  32'h0000);
    check("rst_alu_neg",  32'(ALU_OUT_Fclkneg), 32'd1);
    check("rst_a_neg",    32'(A_Fclkneg_out),   32'd1);

    // Sequencer: one full 26-cycle period after reset release
    reset = 1'b0;
    tick();
    check("inst_first", 32'(instFlag), 32'd1);
    check("step0_clkp", 32'(clkp),     32'h0000);
    for (int c = 1; c < 26; c++) begin
      tick();
      exp_rails = (c <= 13) ? ((32'd1 << c) - 1) : ((32'd1 << (26 - c)) - 1);
      check("ramp_clkp",  32'(clkp),     exp_rails);
      check("ramp_clkn",  32'(clkn),     (~exp_rails) & 32'h1FFF);
      check("ramp_inst",  32'(instFlag), 32'd0);
    end
    tick();
    check("inst_period", 32'(instFlag), 32'd1);
    check("wrap_clkp",   32'(clkp),     32'h0000);

    // Add 1 + 2, captured at the peak
    A_mux = 1; {B_mux1, B_mux0} = 2'b11; {ALU_Control1, ALU_Control0} = 2'b10;
    a = 16'd1; b = 16'd2;
    settle();
    check("add_out",  32'(out),             32'd3);
    check("add_zero", 32'(out_Zero_Detect), 32'd0);
    tick();
    repeat (12) tick();
    check("peak_clkp", 32'(clkp), 32'h1FFF);
    ALU_O_Fclkpos = 1'b1;
    tick();
    ALU_O_Fclkpos = 1'b0;
    check("cap_alu_out", 32'(alu_out),         32'd3);
    check("cap_alu_neg", 32'(ALU_OUT_Fclkneg), 32'd0);
    tick();
    check("cap_alu_neg_back", 32'(ALU_OUT_Fclkneg), 32'd1);
    check("cap_alu_hold",     32'(alu_out),         32'd3);

    // Subtract and set-less-than
    a = 16'd5; b = 16'd7; SUB = 1;
    settle(); check("sub_5_7",   32'(out), 32'hFFFE);
    STL = 1;
    settle(); check("slt_5_7",   32'(out), 32'h0001);
    a = 16'd7; b = 16'd5;
    settle(); check("slt_7_5",   32'(out), 32'h0000);
    check("slt_7_5_zero", 32'(out_Zero_Detect), 32'd1);
    a = 16'h8000; b = 16'h0001;
    settle(); check("slt_ovf",   32'(out), 32'h0001);
    STL = 0;
    settle(); check("sub_ovf",   32'(out), 32'h7FFF);

    // Logic ops
    SUB = 0; a = 16'hF0F0; b = 16'h0FF0;
    {ALU_Control1, ALU_Control0} = 2'b00; settle(); check("and", 32'(out), 32'h00F0);
    {ALU_Control1, ALU_Control0} = 2'b01; settle(); check("or",  32'(out), 32'hFFF0);
    {ALU_Control1, ALU_Control0} = 2'b11; settle(); check("xor", 32'(out), 32'hFF00);

    // Equal operands subtract to zero; add wraps with carry discarded
    {ALU_Control1, ALU_Control0} = 2'b10; SUB = 1; a = 16'h1234; b = 16'h1234;
    settle(); check("eq_zero_det", 32'(out_Zero_Detect), 32'd1);
    check("eq_out", 32'(out), 32'h0000);
    SUB = 0; a = 16'hFFFF; b = 16'h0001;
    settle(); check("wrap_add",  32'(out), 32'h0000);
    check("wrap_zero_det", 32'(out_Zero_Detect), 32'd1);
    a = 16'd1; b = 16'd2; Adder_Cin = 1;
    settle(); check("add_cin",   32'(out), 32'd4);
    Adder_Cin = 0;

    // B operand sources, observed through OR with a = 0
    {ALU_Control1, ALU_Control0} = 2'b01; a = 16'h0000;
    instr_in = 16'h00FF;
    {B_mux1, B_mux0} = 2'b01; settle(); check("b_sext_ff", 32'(out), 32'hFFFF);
    {B_mux1, B_mux0} = 2'b10; settle(); check("b_zext_ff", 32'(out), 32'h00FF);
    instr_in = 16'hAB80;
    {B_mux1, B_mux0} = 2'b01; settle(); check("b_sext_80", 32'(out), 32'hFF80);
    {B_mux1, B_mux0} = 2'b10; settle(); check("b_zext_80", 32'(out), 32'h0080);
    instr_in = 16'h1234;
    {B_mux1, B_mux0} = 2'b01; settle(); check("b_sext_34", 32'(out), 32'h0034);
    {B_mux1, B_mux0} = 2'b00; settle(); check("b_one",     32'(out), 32'h0001);

    // Output mux
    PC_in = 16'hBEEF; instr_in = 16'hC0DE;
    {mux3_1, mux3_0} = 2'b01; settle(); check("out_pc",      32'(out), 32'hBEEF);
    {mux3_1, mux3_0} = 2'b10; settle(); check("out_instr",   32'(out), 32'hC0DE);
    {mux3_1, mux3_0} = 2'b11; settle(); check("out_alu_reg", 32'(out), 32'h0003);
    {mux3_1, mux3_0} = 2'b00;

    // A capture from PC_in
    tick();
    A_mux = 0; PC_in = 16'h1234; A_Fclkpos = 1'b1;
    tick();
    A_Fclkpos = 1'b0;
    check("cap_sram",  32'(SRAM_in),       32'h1234);
    check("cap_a_neg", 32'(A_Fclkneg_out), 32'd0);
    tick();
    check("cap_a_neg_back", 32'(A_Fclkneg_out), 32'd1);
    check("cap_sram_hold",  32'(SRAM_in),       32'h1234);

    // Reset at step 7 with both strobes held high
    for (int i = 0; i < 60; i++) begin
      if (instFlag) break;
      tick();
    end
    check("wait_instflag", 32'(instFlag), 32'd1);
    repeat (7) tick();
    check("step7_clkp", 32'(clkp), 32'h007F);
    PC_in = 16'h5555; A_Fclkpos = 1'b1; ALU_O_Fclkpos = 1'b1; reset = 1'b1;
    tick();
    check("mid_rst_sram",  32'(SRAM_in),  32'h0000);
    check("mid_rst_alu",   32'(alu_out),  32'h0000);
    check("mid_rst_aneg",  32'(A_Fclkneg_out),   32'd1);
    check("mid_rst_alneg", 32'(ALU_OUT_Fclkneg), 32'd1);
    check("mid_rst_inst",  32'(instFlag), 32'd0);
    check("mid_rst_clkp",  32'(clkp),     32'h0000);
    check("mid_rst_clkn",  32'(clkn),     32'h1FFF);
    A_Fclkpos = 1'b0; ALU_O_Fclkpos = 1'b0; reset = 1'b0;
    tick();
    check("restart_inst", 32'(instFlag), 32'd1);
    check("restart_clkp", 32'(clkp),     32'h0000);
    tick();
    check("restart_step1", 32'(clkp),     32'h0001);
    check("restart_inst0", 32'(instFlag), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bennett_alu_datapath.md
Name: bennett_alu_datapath

Overview:
- 16-bit ALU datapath for the adiabatic core, with an integrated WIDTH-phase Bennett clock sequencer.
- The sequencer ramps its phase rails up one at a time and then back down in reverse order, once per instruction.
- The ALU computes AND/OR/XOR/add/sub/set-less-than from selectable operands.
- Results and the A operand are captured into registers on slow-clock strobes.

Parameters:
- WIDTH, 13, number of Bennett clock phases; one instruction period is 2*WIDTH clk cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instFlag  output  1  high for one cycle at step 0 of every Bennett period
- clkp  output  WIDTH  positive phase rails
- clkn  output  WIDTH  negative rails; always equal to ~clkp
- a, b, PC_in, instr_in  input  16  operand sources
- A_mux  input  1  A operand select: 0 = PC_in, 1 = a
- B_mux1, B_mux0  input  1 each  B operand select
- ALU_Control1, ALU_Control0  input  1 each  operation select
- SUB  input  1  subtract mode
- STL  input  1  set-less-than
- Adder_Cin  input  1  carry-in
- mux3_1, mux3_0  input  1 each  select for out
- ALU_O_Fclkpos  input  1  result capture strobe
- A_Fclkpos  input  1  A operand capture strobe
- alu_out  output  16  registered result
- out  output  16  combinational output mux
- SRAM_in  output  16  registered A operand, used as store data
- out_Zero_Detect  output  1  combinational: result == 0
- ALU_OUT_Fclkneg, A_Fclkneg_out  output  1 each  registered complements of the two capture strobes

Behaviour:
- Step counter
  - Range 0..2*WIDTH-1; increments every clk and wraps to 0.
  - Reset forces step 0, clkp = 0, clkn = all ones.
- Phase rails (all outputs registered from step)
  - clkp[i] = 1 iff (i < step <= WIDTH) or (step > WIDTH and i < 2*WIDTH - step).
  - At step WIDTH all rails are high (the peak); at step 0 all rails are low.
- instFlag
  - Equals (step == 0).
  - It is high in the first cycle after reset deasserts, then every 26 cycles at the default WIDTH.
- B operand, selected by {B_mux1,B_mux0}:
  - 00: 16'h0001
  - 01: sign-extended instr_in[7:0]
  - 10: zero-extended instr_in[7:0]
  - 11: b
- Adder
  - sum = A + (SUB ? ~B : B) + (SUB | Adder_Cin), modulo 2^16.
  - The carry-out is discarded.
- Set-less-than
  - slt = sign(sum) XOR signed overflow, computed with SUB forced to 1.
  - When STL = 1 the adder path produces {15'b0, slt}.
- Result, selected by {ALU_Control1,ALU_Control0}:
  - 00: A & B
  - 01: A | B
  - 10: adder path
  - 11: A ^ B
- out_Zero_Detect = (result == 16'h0000); combinational.
- out, selected by {mux3_1,mux3_0}:
  - 00: result
  - 01: PC_in
  - 10: instr_in
  - 11: alu_out
- Capture registers
  - On a clk edge with ALU_O_Fclkpos = 1: alu_out <= result.
  - On a clk edge with A_Fclkpos = 1: SRAM_in <= A. Otherwise both hold.
  - ALU_OUT_Fclkneg <= ~ALU_O_Fclkpos and A_Fclkneg_out <= ~A_Fclkpos, every cycle.
- Reset values: alu_out = 0, SRAM_in = 0, ALU_OUT_Fclkneg = 1, A_Fclkneg_out = 1, instFlag = 0. Reset overrides all strobes.
- Reset mid-period: the sequence restarts at step 0 on the following cycle and captured data clears.
- Latency: result is combinational; alu_out updates 1 clk after the strobe is sampled.

Test Plan:
- Reset, then release → instFlag pulses 1 cycle later and every 26 cycles; clkp rises 0x0001 → 0x1FFF over 13 steps (peak at step 13) and falls in reverse order; clkn == ~clkp at every step.
- Control = 10, A_mux = 1, B_mux = 11, a = 1, b = 2, SUB = 0, STL = 0, Cin = 0, ALU_O_Fclkpos pulsed at the peak → alu_out = 3, out_Zero_Detect = 0.
- a = 5, b = 7, SUB = 1 → result 0xFFFE. Then STL = 1 → result 0x0001. Then a = 0x8000, b = 1 (overflow case) → slt = 1.
- a = 0xF0F0, b = 0x0FF0 with control 00/01/11 → 0x00F0 / 0xFFF0 / 0xFF00. Then a = b, SUB = 1, control 10 → zero detect = 1.
- B_mux = 01 with instr_in = 0x00FF → B = 0xFFFF; B_mux = 10 → B = 0x00FF. mux3 = 01/10 → out = PC_in / instr_in.
- A_Fclkpos pulse with A_mux = 0, PC_in = 0x1234 → SRAM_in = 0x1234 next cycle and A_Fclkneg_out low for 1 cycle. Assert reset at step 7 → SRAM_in = 0 and step restarts at 0.
